snd_gen: RTL and testbench

Four-channel square-wave tone generator that consumes the CPU's sound write port (snd_wen, w_param, w_index, w_val). It sits directly downstream of the c16 core. Each write updates one parameter of one channel. Free-running tick counters generate the tones, and the channels are mixed into a 6-bit sample plus a 1-bit PWM audio pin.

---
 rtl/snd_gen_if.sv | 10 +
 rtl/snd_gen.sv | 132 +++++++++++++
 tb/tb_snd_gen.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/snd_gen_if.sv
// Sound write port from the c16 core: one-cycle strobe plus parameter/channel/data.
interface snd_gen_if;
  logic        snd_wen;
  logic [1:0]  w_param;
  logic [10:0] w_index;
  logic [15:0] w_val;

  modport master (output snd_wen, w_param, w_index, w_val);
  modport slave  (input  snd_wen, w_param, w_index, w_val);
endinterface

// File: rtl/snd_gen.sv
// Four-channel square-wave tone generator: per-channel period/volume/duration,
// shared tick and duration prescalers, 6-bit mixed sample and 1-bit PWM output.
module snd_gen #(
  parameter int unsigned TICK_DIV = 50,
  parameter int unsigned DUR_DIV  = 1000
) (
  input  logic       clk,
  input  logic       resetn,
  snd_gen_if.slave   bus,
  output logic [5:0] sample,
  output logic       pwm_out,
  output logic [3:0] active
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [15:0] DUR_LAST  = 16'(DUR_DIV - 1);

  logic [15:0] tcnt;
  logic [15:0] dcnt;
  logic [5:0]  pcnt;
  logic        tick;
  logic        dtick;
  logic        wr_hit;
  logic [3:0]  en_vec;
  logic [3:0]  contrib [4];
  logic [5:0]  mix;

  assign tick   = (tcnt == TICK_LAST);
  assign dtick  = tick && (dcnt == DUR_LAST);
  assign wr_hit = bus.snd_wen && (bus.w_index[10:2] == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tcnt <= '0;
      dcnt <= '0;
      pcnt <= '0;
    end else begin
      tcnt <= tick ? '0 : tcnt + 16'd1;
      if (tick) begin
        dcnt <= (dcnt == DUR_LAST) ? '0 : dcnt + 16'd1;
      end
      pcnt <= pcnt + 6'd1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_ch
    logic [15:0] period;
    logic [15:0] dur;
    logic [15:0] phase;
    logic [15:0] dur_cnt;
    logic [3:0]  vol;
    logic        en;
    logic        level;
    logic        sel;

    assign sel = wr_hit && (bus.w_index[1:0] == 2'(g));

    // Timed updates first; a write to this channel is applied last so it
    // overrides any field it touches on a tick/dtick cycle.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        period  <= '0;
        dur     <= '0;
        phase   <= '0;
        dur_cnt <= '0;
        vol     <= '0;
        en      <= 1'b0;
        level   <= 1'b0;
      end else begin
        if (tick && en && (period != '0)) begin
          if (phase == period - 16'd1) begin
            phase <= '0;
            level <= ~level;
          end else begin
            phase <= phase + 16'd1;
          end
        end
        if (dtick && en && (dur != '0)) begin
          if (dur_cnt == 16'd1) begin
            en    <= 1'b0;
            level <= 1'b0;
          end else begin
            dur_cnt <= dur_cnt - 16'd1;
          end
        end
        if (sel) begin
          case (bus.w_param)
            2'd0: begin
              period <= bus.w_val;
              phase  <= '0;
              level  <= 1'b0;
            end
            2'd1: vol <= bus.w_val[3:0];
            2'd2: begin
              dur     <= bus.w_val;
              dur_cnt <= bus.w_val;
            end
            default: begin
              en <= bus.w_val[0];
              if (bus.w_val[0]) begin
                phase   <= '0;
                level   <= 1'b0;
                dur_cnt <= dur;
              end
            end
          endcase
        end
      end
    end

    assign en_vec[g]  = en;
    assign contrib[g] = (en && level) ? vol : 4'd0;
  end

  always_comb begin
    mix = {2'b00, contrib[0]} + {2'b00, contrib[1]}
        + {2'b00, contrib[2]} + {2'b00, contrib[3]};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sample  <= '0;
      pwm_out <= 1'b0;
    end else begin
      sample  <= mix;
      pwm_out <= (pcnt < sample);
    end
  end

  assign active = en_vec;

endmodule

// File: tb/tb_snd_gen.sv
// Randomized and directed checks of snd_gen against an edge-counting reference model.
module tb_snd_gen;
  localparam int unsigned TD = 4;
  localparam int unsigned DD = 2;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [5:0] sample;
  logic       pwm_out;
  logic [3:0] active;

  snd_gen_if bus ();

  snd_gen #(.TICK_DIV(TD), .DUR_DIV(DD)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .bus     (bus.slave),
    .sample  (sample),
    .pwm_out (pwm_out),
    .active  (active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned period;
    int unsigned vol;
    int unsigned dur;
    int unsigned en;
    int unsigned phase;
    int unsigned level;
    int unsigned dur_cnt;
  } ch_t;

  ch_t         m [4];
  int unsigned k;
  int unsigned m_sample;
  int unsigned m_pwm;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_active();
    logic [3:0] a = '0;
    for (int c = 0; c < 4; c++) if (m[c].en != 0) a |= 4'(1 << c);
    return a;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) m[c] = '{default: 0};
    k = 0;
    m_sample = 0;
    m_pwm = 0;
  endtask

  // k counts clock edges since reset release; prescalers follow from k alone.
  task automatic model_edge(input logic wen, input logic [1:0] p, input logic [10:0] idx,
                            input logic [15:0] val);
    ch_t nx [4];
    int unsigned mixsum = 0;
    bit tk, dtk;
    k++;
    m_pwm = (((k - 1) % 64) < m_sample) ? 1 : 0;
    for (int c = 0; c < 4; c++) if (m[c].en != 0 && m[c].level != 0) mixsum += m[c].vol;
    m_sample = mixsum;
    tk  = (k % TD) == 0;
    dtk = (k % (TD * DD)) == 0;
    for (int c = 0; c < 4; c++) begin
      nx[c] = m[c];
      if (tk && m[c].en != 0 && m[c].period != 0) begin
        nx[c].phase = (m[c].phase + 1) % m[c].period;
        if (nx[c].phase == 0) nx[c].level = 1 - m[c].level;
      end
      if (dtk && m[c].en != 0 && m[c].dur != 0) begin
        if (m[c].dur_cnt == 1) begin
          nx[c].en = 0;
          nx[c].level = 0;
        end else begin
          nx[c].dur_cnt = m[c].dur_cnt - 1;
        end
      end
      if (wen && idx[10:2] == 9'd0 && int'(idx[1:0]) == c) begin
        case (p)
          2'd0: begin nx[c].period = 32'(val); nx[c].phase = 0; nx[c].level = 0; end
          2'd1: nx[c].vol = 32'(val) % 16;
          2'd2: begin nx[c].dur = 32'(val); nx[c].dur_cnt = 32'(val); end
          default: begin
            nx[c].en = 32'(val) % 2;
            if (val[0]) begin
              nx[c].phase = 0;
              nx[c].level = 0;
              nx[c].dur_cnt = m[c].dur;
            end
          end
        endcase
      end
    end
    for (int c = 0; c < 4; c++) m[c] = nx[c];
  endtask

  task automatic step(input logic wen, input logic [1:0] p, input logic [10:0] idx,
                      input logic [15:0] val);
    @(negedge clk);
    bus.snd_wen = wen;
    bus.w_param = p;
    bus.w_index = idx;
    bus.w_val   = val;
    @(posedge clk);
    if (resetn) model_edge(wen, p, idx, val);
    else        model_reset();
    #1;
    check("sample", 32'(sample), m_sample);
    check("pwm_out", 32'(pwm_out), m_pwm);
    check("active", 32'(active), 32'(m_active()));
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) step(1'b0, 2'd0, 11'd0, 16'd0);
  endtask

  task automatic wr(input int unsigned c, input int unsigned p, input int unsigned val);
    step(1'b1, 2'(p), {9'd0, 2'(c)}, 16'(val));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int unsigned cnt;
    int unsigned hi;
    bus.snd_wen = 1'b0;
    bus.w_param = '0;
    bus.w_index = '0;
    bus.w_val   = '0;
    model_reset();

    // Writes while held in reset must be lost
    resetn = 1'b0;
    wr(0, 0, 3); wr(0, 1, 15); wr(0, 3, 1);
    check("rst_sample", 32'(sample), 0);
    check("rst_pwm", 32'(pwm_out), 0);
    check("rst_active", 32'(active), 0);
    #1 resetn = 1'b1;
    idle(6);
    check("post_rst_active", 32'(active), 0);

    // Single tone on ch0, period 3 ticks -> 12-clock half periods
    wr(0, 0, 3); wr(0, 1, 15); wr(0, 3, 1);
    check("tone_active", 32'(active), 32'h1);
    cnt = 0;
    while (sample != 6'd15 && cnt < 40) begin idle(1); cnt++; end
    check("tone_rise_seen", 32'(sample), 15);
    cnt = 0;
    do begin idle(1); cnt++; end while (sample == 6'd15 && cnt < 40);
    check("tone_half_hi", cnt, 12);
    cnt = 0;
    do begin idle(1); cnt++; end while (sample == 6'd0 && cnt < 40);
    check("tone_half_lo", cnt, 12);

    // Duration expiry on ch1
    wr(0, 3, 0);
    wr(1, 2, 5); wr(1, 0, 1); wr(1, 1, 7); wr(1, 3, 1);
    check("dur_active", 32'(active), 32'h2);
    cnt = 0;
    while (active[1] && cnt < 60) begin idle(1); cnt++; end
    check("dur_expire_window", 32'(cnt >= 33 && cnt <= 40), 1);
    idle(2);
    check("dur_silent", 32'(sample), 0);

    // Writes to a non-zero upper index are ignored
    for (int p = 0; p < 4; p++) step(1'b1, 2'(p), 11'd5, 16'hFFFF);
    check("addr_filter", 32'(active), 0);
    wr(0, 1, 16'hFFF3); wr(0, 3, 1);
    cnt = 0;
    while (sample == 6'd0 && cnt < 40) begin idle(1); cnt++; end
    check("vol_mask", 32'(sample), 3);

    // Enable write landing exactly on the expiry dtick wins
    wr(0, 3, 0);
    wr(2, 0, 2); wr(2, 1, 5); wr(2, 2, 1); wr(2, 3, 1);
    cnt = 0;
    while (((k + 1) % (TD * DD)) != 0 && cnt < 20) begin idle(1); cnt++; end
    wr(2, 3, 1);
    check("conflict_en", 32'(active[2]), 1);
    idle(TD * DD - 1);
    check("conflict_hold", 32'(active[2]), 1);
    idle(1);
    check("conflict_expire", 32'(active[2]), 0);

    // All four channels full volume: sample 60, PWM high 60 of 64 clocks
    for (int c = 0; c < 4; c++) begin wr(c, 0, 100); wr(c, 1, 15); wr(c, 2, 0); end
    for (int c = 0; c < 4; c++) wr(c, 3, 1);
    idle(450);
    check("mix_full", 32'(sample), 60);
    hi = 0;
    for (int i = 0; i < 64; i++) begin idle(1); if (pwm_out) hi++; end
    check("pwm_duty", hi, 60);
    check("mix_full_end", 32'(sample), 60);

    // Randomized traffic with occasional asynchronous reset
    for (int i = 0; i < 3000; i++) begin
      int unsigned r, c, p, v;
      logic [10:0] idx;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        #1 resetn = 1'b0;
        model_reset();
        #1;
        check("async_rst_sample", 32'(sample), 0);
        check("async_rst_pwm", 32'(pwm_out), 0);
        check("async_rst_active", 32'(active), 0);
        idle(2);
        #1 resetn = 1'b1;
      end else if (r < 20) begin
        c = $urandom_range(0, 3);
        p = $urandom_range(0, 3);
        idx = ($urandom_range(0, 9) == 0) ? 11'($urandom) : {9'd0, 2'(c)};
        case (p)
          0: v = $urandom_range(0, 6);
          1: v = $urandom;
          2: v = $urandom_range(0, 4);
          default: v = $urandom_range(0, 7);
        endcase
        step(1'b1, 2'(p), idx, 16'(v));
      end else begin
        idle(1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
